// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory bus between the instruction
// fetch (IF) port and the load/store (MEM) port. One access is in flight at a
// time. Conflicting requests alternate, and a bounded wait counter aborts any
// access the memory never acknowledges.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  // load/store port
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_ack_o,
  output logic [31:0] mem_rdata_o,
  // pipeline controller
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  // external bus
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_e;

  // Counter value in the last busy cycle before the access is abandoned.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 last_mem_q, last_mem_d;   // 1: MEM was served last
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 bus_ce_q, bus_ce_d;
  logic                 bus_we_q, bus_we_d;
  logic [31:0]          bus_addr_q, bus_addr_d;
  logic [3:0]           bus_sel_q, bus_sel_d;
  logic [31:0]          bus_wdata_q, bus_wdata_d;
  logic                 bus_err_q, bus_err_d;
  logic                 if_ack_q, if_ack_d;
  logic                 mem_ack_q, mem_ack_d;
  logic [31:0]          if_rdata_q, if_rdata_d;
  logic [31:0]          mem_rdata_q, mem_rdata_d;

  logic                 grant_mem;
  logic                 done;
  logic                 expired;

  // Next-state logic: arbitration in IDLE, completion/timeout while busy.
  always_comb begin
    state_d     = state_q;
    last_mem_d  = last_mem_q;
    cnt_d       = cnt_q;
    bus_ce_d    = bus_ce_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    bus_err_d   = 1'b0;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    // MEM wins unless IF is also waiting and MEM had the previous turn.
    grant_mem   = mem_req_i & ~(if_req_i & last_mem_q);
    done        = 1'b0;
    expired     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_mem) begin
          state_d     = BUSY_MEM;
          bus_ce_d    = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_sel_d   = mem_sel_i;
          bus_wdata_d = mem_wdata_i;
        end else if (if_req_i) begin
          state_d    = BUSY_IF;
          bus_ce_d   = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr_i;
          bus_sel_d  = 4'b1111;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        done    = bus_ack_i;
        expired = ~bus_ack_i & (cnt_q == CNT_LAST);
        if (done || expired) begin
          state_d    = IDLE;
          bus_ce_d   = 1'b0;
          cnt_d      = '0;
          bus_err_d  = expired;
          last_mem_d = (state_q == BUSY_MEM);
          // A requester that flushed its request still gets its data
          // updated, but receives no acknowledge.
          if (state_q == BUSY_IF) begin
            if_ack_d   = if_req_i;
            if_rdata_d = expired ? 32'd0 : bus_rdata_i;
          end else begin
            mem_ack_d = mem_req_i;
            if (expired) begin
              mem_rdata_d = 32'd0;
            end else if (!bus_we_q) begin
              mem_rdata_d = bus_rdata_i;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_mem_q  <= 1'b0;
      cnt_q       <= '0;
      bus_ce_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_sel_q   <= 4'd0;
      bus_wdata_q <= 32'd0;
      bus_err_q   <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      cnt_q       <= cnt_d;
      bus_ce_q    <= bus_ce_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      bus_err_q   <= bus_err_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus_ce_o    = bus_ce_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_err_o   = bus_err_q;
  assign if_ack_o    = if_ack_q;
  assign mem_ack_o   = mem_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;

  // A port stalls the pipeline until the cycle its acknowledge is presented.
  assign stallreq_if_o  = ~reset & if_req_i  & ~if_ack_q;
  assign stallreq_mem_o = ~reset & mem_req_i & ~mem_ack_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external single-port memory bus between the instruction-fetch port (IF) and the load/store port (MEM) of the 5-stage pipeline.
- Sequences each access with a registered request/ack handshake and tolerates variable memory latency.
- Returns read data to the requester that issued the access.
- Raises per-port stall requests to the pipeline controller until that port is served.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in a busy state before the access is aborted.
- CNT_WIDTH, 8: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- if_req_i  in  1  IF requests a word read.
- if_addr_i  in  32  IF byte address, word aligned.
- if_ack_o  out  1  one-cycle pulse: if_rdata_o valid.
- if_rdata_o  out  32  fetched instruction.
- mem_req_i  in  1  MEM requests an access.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_addr_i  in  32  MEM byte address.
- mem_sel_i  in  4  byte enables (LB/SB: one-hot; LW/SW: 4'b1111).
- mem_wdata_i  in  32  store data.
- mem_ack_o  out  1  one-cycle pulse: access complete.
- mem_rdata_o  out  32  load data.
- stallreq_if_o  out  1  IF stall request to the pipeline controller.
- stallreq_mem_o  out  1  MEM stall request to the pipeline controller.
- bus_ce_o  out  1  external bus cycle active.
- bus_we_o  out  1  external write strobe.
- bus_addr_o  out  32  external address.
- bus_sel_o  out  4  external byte enables.
- bus_wdata_o  out  32  external write data.
- bus_rdata_i  in  32  external read data, valid with bus_ack_i.
- bus_ack_i  in  1  external completion.
- bus_err_o  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (synchronous, while reset=1):
  - state=IDLE, last_grant=IF, counter=0.
  - All outputs 0: bus_* = 0, acks = 0, rdata = 0, bus_err_o = 0.
  - Stall outputs are 0 while reset=1.
  - Reset asserted mid-access drops bus_ce_o at the next edge. No ack is issued. The in-flight access is abandoned.
- States: IDLE, BUSY_IF, BUSY_MEM.
- IDLE:
  - Only mem_req_i=1: latch mem_* onto bus_* registers, bus_ce_o=1, bus_we_o=mem_we_i, go to BUSY_MEM.
  - Only if_req_i=1: latch if_addr_i, bus_we_o=0, bus_sel_o=4'b1111, go to BUSY_IF.
  - Both requests: grant the port that is not last_grant. MEM wins on the first conflict after reset.
  - Neither: stay in IDLE, bus_ce_o=0.
- BUSY_x:
  - bus_* outputs are held stable. The counter increments each cycle.
  - On bus_ack_i=1:
    - Capture bus_rdata_i into x_rdata_o (writes leave it unchanged).
    - Pulse x_ack_o for exactly one cycle.
    - Set last_grant=x, bus_ce_o=0, counter=0, go to IDLE.
  - If counter == TIMEOUT_CYCLES-1 and bus_ack_i=0:
    - Pulse bus_err_o and x_ack_o.
    - x_rdata_o=0, bus_ce_o=0, go to IDLE.
  - bus_ack_i arriving in the same cycle as the timeout: treated as a normal ack, no error.
- Latency: request sampled at edge N, then bus_ce_o=1 after edge N. Ack sampled at edge M, then x_ack_o=1 after edge M. Minimum request-to-ack is 2 cycles with a zero-wait bus.
- At least one IDLE cycle occurs between consecutive bus accesses.
- Stall outputs: stallreq_x_o = x_req_i & ~x_ack_o. This is combinational from registered ack and input request.
- Requester drops x_req_i mid-access (flush):
  - The bus access still runs to completion, so writes are never torn.
  - x_ack_o is suppressed if x_req_i=0 in the ack cycle. rdata is still updated.
- bus_ack_i while in IDLE: ignored.
- Requester input changes while busy: ignored until the next IDLE.

Test Plan:
- Zero-wait bus, if_req_i=1 with addr 0x00000010, bus_ack_i returned one cycle after bus_ce_o with rdata 0x34010005 → bus_addr_o=0x10, bus_sel_o=4'hF. if_ack_o pulses with if_rdata_o=0x34010005 two cycles after the request. stallreq_if_o falls in the ack cycle.
- Both requests asserted from reset; MEM is an SW to 0x100 with data 0xDEADBEEF; 3-wait bus → MEM is served first with bus_we_o=1, sel=F. Then one IDLE cycle. Then the IF access is issued. stallreq_if_o stays high throughout the MEM access.
- Two back-to-back conflicts → grants alternate MEM, IF, MEM, IF. No port is served twice in a row while the other is pending.
- SB to 0x203 with sel=4'b1000 → bus_sel_o=4'b1000, bus_wdata_o unchanged for all busy cycles. LB from 0x203 returns bus_rdata_i in mem_rdata_o.
- Bus never acks, TIMEOUT_CYCLES=4 → bus_ce_o high for 4 cycles, then bus_err_o and x_ack_o pulse together with rdata=0. The state returns to IDLE.
- reset asserted in the second busy cycle → bus_ce_o=0 and state IDLE after that edge, no acks. mem_req_i dropped mid-access → bus completes and mem_ack_o stays 0.
